// File: rtl/lsu_mem_port.sv
`default_nettype none
// lsu_mem_port: load/store unit bridging the MEM stage to a ready-handshaked data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module lsu_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                stall_o,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [LANE_W-1:0]   req_lane, size_m1, lane_al;
  logic [BE_W-1:0]     size_be;
  logic                req_illegal;
  logic [DATA_W-1:0]   ld_sh, ld_mask, ld_fmt;
  logic                ld_sign;

  always_comb begin
    req_lane = req_addr_i[LANE_W-1:0];
    case (req_funct3_i[1:0])
      2'b00:   begin size_m1 = '0;            size_be = BE_W'(1);     end
      2'b01:   begin size_m1 = LANE_W'(1);    size_be = BE_W'(2'b11); end
      2'b10:   begin size_m1 = LANE_W'(3);    size_be = BE_W'(4'hF);  end
      default: begin size_m1 = LANE_W'(7);    size_be = '1;           end
    endcase
    req_illegal = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]) ||
                  ((req_funct3_i[1:0] == 2'b11) && (DATA_W < 64));
    lane_al     = req_lane & ~size_m1;
  end

  // Load data: shift the addressed lane down, then sign- or zero-extend above the access size.
  always_comb begin
    ld_sh = mem_rdata_i >> {lane_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   begin ld_mask = DATA_W'(8'hFF);        ld_sign = ld_sh[7];        end
      2'b01:   begin ld_mask = DATA_W'(16'hFFFF);     ld_sign = ld_sh[15];       end
      2'b10:   begin ld_mask = DATA_W'(32'hFFFF_FFFF); ld_sign = ld_sh[31];      end
      default: begin ld_mask = '1;                    ld_sign = ld_sh[DATA_W-1]; end
    endcase
    ld_fmt = (ld_sh & ld_mask) | ({DATA_W{ld_sign & ~f3_q[2]}} & ~ld_mask);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          err_d   = 1'b0;
          rdata_d = '0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (|(req_lane & size_m1)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
          else begin
            we_d    = req_we_i;
            f3_d    = req_funct3_i;
            lane_d  = lane_al;
            addr_d  = {req_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            be_d    = size_be << lane_al;
            wdata_d = req_wdata_i << {lane_al, 3'b000};
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ready_i) begin
          rdata_d = we_q ? '0 : ld_fmt;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE stall is combinational and must also read 0 while reset is held.
  assign stall_o      = (state_q == ACCESS) || ((state_q == IDLE) && req_valid_i && rst_ni);
  assign mem_rd_o     = (state_q == ACCESS) && !we_q;
  assign mem_wr_o     = (state_q == ACCESS) && we_q;
  assign mem_addr_o   = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_be_o     = (state_q == ACCESS) ? be_q    : '0;
  assign mem_wdata_o  = (state_q == ACCESS) ? wdata_q : '0;
  assign resp_valid_o = (state_q == RESP);
  assign resp_err_o   = (state_q == RESP) && err_q;
  assign resp_rdata_o = (state_q == RESP) ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// tb_lsu_mem_port: randomized scoreboard bench against a byte-array memory reference model.
module tb_lsu_mem_port;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 16;
  localparam int BE = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          stall, resp_valid, resp_err, mem_rd, mem_wr;
  logic [DW-1:0] resp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BE-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  lsu_mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .stall_o(stall), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  logic [7:0] mem_b [0:(1<<AW)-1];
  logic [7:0] ref_b [0:(1<<AW)-1];

  int            cur_wait = 0;
  logic          exp_strobe = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [BE-1:0] exp_be = '0;
  logic [DW-1:0] exp_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic poke(input int addr, input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      mem_b[addr+i] = val[8*i +: 8];
      ref_b[addr+i] = val[8*i +: 8];
    end
  endtask

  // Memory: asserts ready once the access has waited cur_wait cycles; never if that exceeds the timeout.
  int acc_cyc = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_rd || mem_wr) begin
        if (acc_cyc == cur_wait && cur_wait < TO-1) begin
          mem_ready = 1'b1;
          for (int i = 0; i < BE; i++) begin
            mem_rdata[8*i +: 8] = mem_b[int'(mem_addr) + i];
            if (mem_wr && mem_be[i]) mem_b[int'(mem_addr) + i] = mem_wdata[8*i +: 8];
          end
        end else begin
          mem_rdata = DW'($urandom);
        end
        acc_cyc++;
      end else begin
        acc_cyc = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_rd || mem_wr) begin
        check("strobe_allowed", exp_strobe, 1);
        check("strobe_dir", {mem_wr, mem_rd}, exp_we ? 2'b10 : 2'b01);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", mem_be, exp_be);
        if (mem_wr) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (resp_valid) begin
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_err", resp_err, e.err);
          check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int w, input logic rsp_junk);
    int n, a, lane, exp_lat, lat;
    logic illegal, trap, stall_ok;
    logic [63:0] v;
    exp_t e;
    n       = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (we && f3[2]) || (n > BE);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(addr) % n) != 0;
`else
    trap = 1'b0;
`endif
    a = int'(addr) - (int'(addr) % n);
    lane = a % BE;
    e.rdata = '0;
    e.err   = 1'b0;
    if (illegal || trap) begin
      e.err = 1'b1;
      exp_lat = 1;
      exp_strobe = 1'b0;
    end else begin
      exp_strobe = 1'b1;
      exp_we     = we;
      exp_addr   = AW'(a - lane);
      exp_be     = BE'(((1 << n) - 1) << lane);
      exp_wdata  = DW'(64'(wdata) << (8 * lane));
      if (w >= TO-1) begin
        e.err = 1'b1;
        exp_lat = TO;
      end else begin
        exp_lat = w + 2;
        if (we) begin
          for (int i = 0; i < n; i++) ref_b[a+i] = wdata[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < n; i++) v = v | (64'(ref_b[a+i]) << (8*i));
          if (!f3[2] && v[8*n-1] && n < 8) v = v | (~64'(0) << (8*n));
          e.rdata = DW'(v);
        end
      end
    end
    cur_wait = w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    exp_q.push_back(e);
    #1 check("stall_idle_req", stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = AW'($urandom); req_wdata = DW'($urandom);
    lat = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid && !stall) stall_ok = 1'b0;
    end while (!resp_valid && lat < 40);
    check("latency", lat, exp_lat);
    check("stall_busy", stall_ok, 1);
    check("stall_resp", stall, 0);
    if (rsp_junk) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = AW'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    #23;
    check("rst_outputs", {stall, resp_valid, resp_err, mem_rd, mem_wr}, 0);
    check("rst_buses", {resp_rdata, mem_addr, mem_be, mem_wdata}, 0);
    @(negedge clk); rst_n = 1'b1;

    poke(0, 32'h80FF_1234);
    do_req(1'b0, 3'b000, 9'h003, '0, 0, 1'b0);
    do_req(1'b1, 3'b001, 9'h006, 32'h0000_ABCD, 3, 1'b0);
    do_req(1'b0, 3'b010, 9'h010, '0, TO-1, 1'b0);
    do_req(1'b0, 3'b010, 9'h014, '0, TO-2, 1'b0);
    do_req(1'b0, 3'b001, 9'h001, '0, 0, 1'b0);
    do_req(1'b0, 3'b011, 9'h008, '0, 0, 1'b0);
    do_req(1'b0, 3'b111, 9'h008, '0, 0, 1'b0);
    do_req(1'b1, 3'b100, 9'h008, 32'h55, 0, 1'b0);

    // Reset in the middle of a store that would otherwise time out.
    exp_strobe = 1'b1; exp_we = 1'b1; exp_addr = 9'h020; exp_be = '1; exp_wdata = 32'hDEAD_BEEF;
    cur_wait = 100;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_wr", mem_wr, 1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_wr", mem_wr, 0);
    check("rst_mid_stall", stall, 0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    #1 check("rst_stall_gated", stall, 0);
    check("rst_mid_all", {resp_valid, resp_err, mem_rd, mem_addr, mem_be, mem_wdata, resp_rdata}, 0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    poke(0, 32'h00F0_0000);
    do_req(1'b0, 3'b100, 9'h002, '0, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      int r, w;
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? int'($urandom_range(0, 3)) : ((r == 7) ? TO-2 : ((r == 8) ? TO-1 : TO));
      do_req(1'($urandom), 3'($urandom), AW'($urandom), DW'($urandom), w, 1'($urandom));
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the pipeline MEM stage and the data memory.
- Replaces the fixed single-cycle word read/write path with the following:
  - byte, half, word and (DATA_W=64) double accesses;
  - a ready-based memory handshake with variable wait states;
  - a timeout counter;
  - error reporting.
- While an access is outstanding it drives stall to freeze the pipeline.

Parameters:
- DATA_W, 32, data bus width in bits; legal values are 32 or 64.
- ADDR_W, 9, byte address width.
- TIMEOUT, 16, maximum ACCESS cycles without mem_ready before the access aborts; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- stall  out  1  pipeline hold.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load result, extended; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: the access failed.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  byte address with lane bits cleared.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rdata  in  DATA_W  full-width read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the current strobe this cycle.

Behaviour:
- Reset (reset=0):
  - state goes to IDLE immediately, without waiting for a clock edge;
  - every output is 0, including mem_rd/mem_wr (an in-flight access is dropped);
  - the timeout counter is cleared.
- Access size comes from funct3[1:0]: 00 = 1 byte, 01 = 2, 10 = 4, 11 = 8.
- Lane = req_addr[log2(DATA_W/8)-1:0].
- A request is illegal when any of these holds:
  - size 8 with DATA_W=32;
  - a store with funct3[2]=1;
  - funct3 = 111.
- A request is misaligned when lane is not a multiple of the access size.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid with a legal, aligned request:
    - latch we, funct3, lane and wdata;
    - next cycle mem_addr = req_addr with the lane bits cleared;
    - mem_be = the size mask shifted left by lane;
    - mem_wdata = req_wdata shifted left by lane×8;
    - go to ACCESS.
  - On req_valid with an illegal request: no memory strobe; go to RESP with resp_err=1.
- ACCESS:
  - mem_rd = !we and mem_wr = we, held constant; stall = 1.
  - Counter increments every cycle.
  - mem_ready=1: register the formatted load data, then go to RESP with resp_err=0.
  - Counter reaches TIMEOUT-1 without mem_ready: drop the strobes and go to RESP with resp_err=1.
  - If mem_ready and timeout fall in the same cycle, mem_ready wins.
- RESP:
  - exactly one cycle; resp_valid=1, stall=0, strobes 0; then IDLE.
  - req_valid is ignored in RESP because the pipeline advances on this edge.
- Load formatting:
  - extract `size` bytes starting at lane from mem_rdata;
  - sign-extend when funct3[2]=0, zero-extend when funct3[2]=1;
  - a full-width load passes mem_rdata through unchanged.
- Latency: request accepted at cycle 0, mem_ready at cycle k ≥ 1, resp_valid at k+1. The minimum is 2 cycles.
- req_* are sampled only in IDLE; changes during ACCESS/RESP have no effect.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - a misaligned request in IDLE produces no memory strobe;
  - RESP follows with resp_err=1 and resp_rdata=0.
- Undefined:
  - a misaligned access is aligned down to its size (the lane's low bits are cleared) and proceeds normally;
  - no error is raised.
- Illegal funct3 always raises an error in both builds.

Test Plan:
1. DATA_W=32, LB at addr 0x003, mem_rdata=0x80FF_1234, mem_ready on the first ACCESS cycle → mem_addr=0x000, mem_be=4'b1000, resp_valid at cycle 2, resp_rdata=0xFFFF_FF80, resp_err=0.
2. SH at addr 0x006, req_wdata=0x0000_ABCD, mem_ready after 3 wait cycles → mem_wr high for 4 cycles, mem_be=4'b1100, mem_wdata=0xABCD_0000, stall high 5 cycles, resp_valid at cycle 5.
3. LW at 0x010, mem_ready held 0, TIMEOUT=16 → strobe drops after 15 ACCESS cycles; resp_valid=1, resp_err=1, resp_rdata=0.
4. LH at 0x001 with LSU_MISALIGN_TRAP_EN → no mem_rd, resp_err=1 at cycle 1. Same request without the macro → mem_be=4'b0011, resp_err=0.
5. reset asserted mid-ACCESS (during a mem_wr) → mem_wr and stall go to 0 immediately. After release, an LBU at 0x002 with mem_rdata=0x00F0_0000 → resp_rdata=0x0000_00F0.
6. DATA_W=64: LD at 0x008 → mem_be=8'hFF and full-width pass-through. LD at DATA_W=32 → resp_err=1 with no strobe.
